rv32i_fetch_unit: RTL and testbench

- Instruction fetch stage for the RV32I core, directly upstream of decode; its if_instr output drives the decode stage's instruction_parser interface.
- Owns the PC and issues word reads to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned words with their PC in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles redirects from execute (branch/jump) by flushing buffered words and discarding in-flight responses.

---
 rtl/rv32i_pkg.sv | 15 +
 rtl/rv32i_fetch_unit_if.sv | 33 +++
 rtl/rv32i_fetch_unit_fifo.sv | 74 +++++++
 rtl/rv32i_fetch_unit.sv | 99 +++++++++
 tb/tb_rv32i_fetch_unit.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I types and constants used by the fetch stage.
package rv32i_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ILEN    = 32;
  localparam int unsigned PC_STEP = 4;

  // One fetched instruction travelling from fetch towards decode
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            fault;
  } fetch_entry_t;

endpackage

// File: rtl/rv32i_fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/response, redirect and decode handshake.
interface rv32i_fetch_unit_if;
  import rv32i_pkg::*;

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            imem_rsp_err;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            if_valid;
  logic            if_ready;
  logic [ILEN-1:0] if_instr;
  logic [XLEN-1:0] if_pc;
  logic            if_fault;

  // Fetch unit side
  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_fault,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
           redirect_valid, redirect_pc, if_ready
  );

  // Memory / execute / decode side
  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc, if_fault,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, imem_rsp_err,
           redirect_valid, redirect_pc, if_ready
  );

endinterface

// File: rtl/rv32i_fetch_unit_fifo.sv
// Small circular buffer with flush; pointers wrap modulo DEPTH (any DEPTH >= 2).
module fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter type         entry_t = logic [31:0]
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  entry_t                     data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output entry_t                     head_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Pointer and occupancy next-state; flush wins over everything
  always_comb begin
    do_pop  = pop_i && (cnt_q != '0);
    do_push = push_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop);
    rd_d    = rd_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = bump(wr_q);
      if (do_pop)  rd_d = bump(rd_q);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Pointer/count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage, cleared on reset so the head reads as zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/rv32i_fetch_unit.sv
// RV32I fetch stage: credit-limited PC sequencer, response buffer and redirect handling.
module rv32i_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst,
  rv32i_fetch_unit_if.master bus
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic [XLEN-1:0] redirect_tgt;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;
  logic             req_valid_c, issue, rsp, dropping, push, pop;
  fetch_entry_t     push_entry, head;

  // Request/response bookkeeping; a redirect turns every outstanding request into a drop
  always_comb begin
    redirect_tgt = bus.redirect_pc & ~XLEN'(3);
    req_valid_c  = ((SUM_W'(inflight_q) + SUM_W'(fifo_count)) < SUM_W'(DEPTH))
                   && !bus.redirect_valid && !rst;
    issue        = req_valid_c && bus.imem_req_ready;
    rsp          = bus.imem_rsp_valid;
    dropping     = rsp && (drop_q != '0);
    push         = rsp && !dropping && !bus.redirect_valid;
    pop          = !fifo_empty && bus.if_ready;

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(rsp);
    drop_d     = drop_q - CNT_W'(dropping);

    if (issue) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
    if (push)  resp_pc_d  = resp_pc_q + XLEN'(PC_STEP);

    if (bus.redirect_valid) begin
      fetch_pc_d = redirect_tgt;
      resp_pc_d  = redirect_tgt;
      drop_d     = inflight_d;
    end

    push_entry = '{pc: resp_pc_q, instr: bus.imem_rsp_data, fault: bus.imem_rsp_err};
  end

  // Fetch state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  // Credits must keep a push from ever landing on a full buffer
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && fifo_full && !pop))
        else $error("rv32i_fetch_unit: fetch buffer overflow");
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.imem_req_valid = req_valid_c;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.if_valid       = !fifo_empty;
  assign bus.if_instr       = head.instr;
  assign bus.if_pc          = head.pc;
  assign bus.if_fault       = head.fault;

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed bench for rv32i_fetch_unit with memory model and in-order scoreboard.
module tb_rv32i_fetch_unit;
  import rv32i_pkg::*;

  localparam int unsigned DEPTH   = 2;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rv32i_fetch_unit_if bus ();
  rv32i_fetch_unit_if bus2 ();

  rv32i_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );
  rv32i_fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_wrap (
    .clk (clk), .rst (rst), .bus (bus2)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  always @(posedge clk) cyc = cyc + 1;

  // ---------------- instruction memory model (in order, programmable latency)
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          mem_lat  = 1;
  logic [31:0] err_addr = 32'h0000_0008;

  always @(posedge clk) begin
    #1;
    if (rst) begin
      mq.delete();
      bus.imem_rsp_valid = 1'b0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mq[0].addr);
      bus.imem_rsp_err   = (mq[0].addr == err_addr);
      void'(mq.pop_front());
    end else begin
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data  = '0;
      bus.imem_rsp_err   = 1'b0;
    end
  end

  // ---------------- scoreboard: push on request accept, pop on decode handshake
  fetch_entry_t sb[$];
  logic [31:0]  exp_req_addr = 32'h0;
  int           live         = 0;
  int           faults_seen  = 0;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      exp_req_addr = 32'h0;
      live         = 0;
    end else begin
      if (bus.if_valid && bus.if_ready) begin
        chk("if_expected_avail", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          chk("if_pc", bus.if_pc, sb[0].pc);
          chk("if_instr", bus.if_instr, sb[0].instr);
          chk("if_fault", 32'(bus.if_fault), 32'(sb[0].fault));
          void'(sb.pop_front());
        end
        if (bus.if_fault) faults_seen++;
        live--;
      end
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        chk("req_addr", bus.imem_req_addr, exp_req_addr);
        sb.push_back('{pc: exp_req_addr, instr: mem_word(exp_req_addr),
                       fault: (exp_req_addr == err_addr)});
        mq.push_back('{addr: bus.imem_req_addr, due: cyc + mem_lat});
        exp_req_addr = exp_req_addr + 32'd4;
        live++;
      end
      if (bus.redirect_valid) begin
        sb.delete();
        exp_req_addr = bus.redirect_pc & ~32'h3;
        live         = 0;
      end
      chk("credit_bound", 32'(live <= int'(DEPTH)), 32'd1);
    end
  end

  // ---------------- wrap-around instance: one-cycle memory, always-ready decode
  logic        wrap_acc      = 1'b0;
  logic        wrap_seen     = 1'b0;
  logic [31:0] wrap_addr_q   = 32'h0;
  logic [31:0] exp_wrap_addr = WRAP_PC;
  logic [31:0] exp_wrap_pc   = WRAP_PC;

  always @(negedge clk) begin
    if (rst) begin
      exp_wrap_addr = WRAP_PC;
      exp_wrap_pc   = WRAP_PC;
      wrap_acc      = 1'b0;
    end else begin
      wrap_acc = bus2.imem_req_valid && bus2.imem_req_ready;
      if (wrap_acc) begin
        chk("wrap_req_addr", bus2.imem_req_addr, exp_wrap_addr);
        if (exp_wrap_addr == 32'h0) wrap_seen = 1'b1;
        wrap_addr_q   = bus2.imem_req_addr;
        exp_wrap_addr = exp_wrap_addr + 32'd4;
      end
      if (bus2.if_valid) begin
        chk("wrap_if_pc", bus2.if_pc, exp_wrap_pc);
        exp_wrap_pc = exp_wrap_pc + 32'd4;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    bus2.imem_rsp_valid = wrap_acc && !rst;
    bus2.imem_rsp_data  = wrap_addr_q;
    bus2.imem_rsp_err   = 1'b0;
  end

  // ---------------- directed sequence
  initial begin
    logic found;
    rst = 1'b1;
    bus.imem_req_ready  = 1'b1;
    bus.imem_rsp_valid  = 1'b0;
    bus.imem_rsp_data   = '0;
    bus.imem_rsp_err    = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = '0;
    bus.if_ready        = 1'b1;
    bus2.imem_req_ready = 1'b1;
    bus2.imem_rsp_valid = 1'b0;
    bus2.imem_rsp_data  = '0;
    bus2.imem_rsp_err   = 1'b0;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = '0;
    bus2.if_ready       = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_if_instr", bus.if_instr, 32'd0);
    chk("rst_if_pc", bus.if_pc, 32'd0);
    chk("rst_if_fault", 32'(bus.if_fault), 32'd0);

    // Sequential fetch, one-cycle memory
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("first_req_valid", 32'(bus.imem_req_valid), 32'd1);
    chk("first_req_addr", bus.imem_req_addr, 32'h0);
    chk("lat_c0_if_valid", 32'(bus.if_valid), 32'd0);
    @(negedge clk);
    chk("lat_c1_rsp_valid", 32'(bus.imem_rsp_valid), 32'd1);
    chk("lat_c1_if_valid", 32'(bus.if_valid), 32'd0);
    @(negedge clk);
    chk("lat_c2_if_valid", 32'(bus.if_valid), 32'd1);
    chk("lat_c2_if_pc", bus.if_pc, 32'h0);
    repeat (20) @(negedge clk);

    // Decode stall for 10 cycles: credits exhaust and requests stop
    @(posedge clk); #1 bus.if_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 4) begin
        chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("stall_if_valid", 32'(bus.if_valid), 32'd1);
      end
    end
    @(posedge clk); #1 bus.if_ready = 1'b1;
    repeat (12) @(negedge clk);

    // Redirect with two requests in flight and an empty buffer
    mem_lat = 6;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (!bus.imem_req_valid && !bus.if_valid && !bus.imem_rsp_valid) found = 1'b1;
    end
    chk("rd1_two_inflight", 32'(found), 32'd1);
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    @(negedge clk);
    chk("rd1_req_valid_R", 32'(bus.imem_req_valid), 32'd0);
    @(posedge clk); #1 bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("rd1_if_valid_R1", 32'(bus.if_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        chk("rd1_next_addr", bus.imem_req_addr, 32'h0000_0100);
        found = 1'b1;
      end else @(negedge clk);
    end
    chk("rd1_req_seen", 32'(found), 32'd1);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (bus.if_valid) begin
        chk("rd1_first_pc", bus.if_pc, 32'h0000_0100);
        found = 1'b1;
      end else @(negedge clk);
    end
    chk("rd1_if_seen", 32'(found), 32'd1);
    mem_lat = 1;
    repeat (15) @(negedge clk);

    // Redirect coinciding with an arriving response and a decode handshake
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk); #2;
      if (bus.if_valid && bus.imem_rsp_valid) found = 1'b1;
    end
    chk("rd2_coincide_found", 32'(found), 32'd1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    @(negedge clk);
    chk("rd2_handshake_R", 32'(bus.if_valid && bus.if_ready), 32'd1);
    @(posedge clk); #1 bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("rd2_if_valid_R1", 32'(bus.if_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (bus.if_valid) begin
        chk("rd2_first_pc", bus.if_pc, 32'h0000_0200);
        found = 1'b1;
      end else @(negedge clk);
    end
    chk("rd2_if_seen", 32'(found), 32'd1);
    repeat (5) @(negedge clk);

    // Back-to-back redirects: the later target wins
    @(posedge clk); #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0300;
    @(posedge clk); #1 bus.redirect_pc = 32'h0000_0400;
    @(posedge clk); #1 bus.redirect_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (bus.if_valid) begin
        chk("b2b_first_pc", bus.if_pc, 32'h0000_0400);
        found = 1'b1;
      end
    end
    chk("b2b_if_seen", 32'(found), 32'd1);
    repeat (6) @(negedge clk);

    // Asynchronous reset mid-stream, then restart from RESET_PC
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (bus.if_valid) found = 1'b1;
    end
    chk("mid_rst_stream_busy", 32'(found), 32'd1);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("async_rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("async_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        chk("restart_addr", bus.imem_req_addr, 32'h0);
        found = 1'b1;
      end
    end
    chk("restart_req_seen", 32'(found), 32'd1);
    repeat (20) @(negedge clk);

    chk("fault_count", 32'(faults_seen), 32'd2);
    chk("wrap_seen", 32'(wrap_seen), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
